// File: rtl/spi_csr_master.sv
// SPI mode-0 master that frames a CSR command as one header byte plus cmd_len data
// bytes under a single nss assertion, streaming write bytes in and read bytes out.
module spi_csr_master #(
  parameter int A_WIDTH = 5,
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [A_WIDTH-1:0] cmd_addr,
  input  logic [7:0]         cmd_len,
  input  logic [7:0]         wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic [7:0]         rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               sck,
  output logic               nss,
  output logic               mosi,
  input  logic               miso
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, WAIT, HOLD, GUARD} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

  state_t             state, state_nxt;
  logic [7:0]         div;
  logic [2:0]         bit_cnt;
  logic [8:0]         byte_cnt;
  logic               wr_cmd;
  logic               hdr;
  logic [A_WIDTH-1:0] addr;
  logic [7:0]         tx;
  logic [7:0]         rx;
  logic [7:0]         hdr_byte;
  logic               accept, tick, last_bit;
  logic               load_hdr, load_data, shift, sample, byte_end;

  assign cmd_ready = reset_n && (state == IDLE);
  assign busy      = (state != IDLE);
  assign sck       = (state == HIGH);
  assign nss       = (state == IDLE) || (state == GUARD);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (div == 8'd0);
  assign last_bit  = (bit_cnt == 3'd0);

  always_comb begin
    hdr_byte             = '0;
    hdr_byte[A_WIDTH-1:0] = addr;
    hdr_byte[7]          = wr_cmd;
  end

  always_comb begin
    state_nxt = state;
    load_hdr  = 1'b0;
    load_data = 1'b0;
    shift     = 1'b0;
    sample    = 1'b0;
    byte_end  = 1'b0;
    wr_ready  = 1'b0;
    case (state)
      IDLE:  if (accept) state_nxt = SETUP;
      SETUP: if (tick) begin
        state_nxt = LOW;
        load_hdr  = 1'b1;
      end
      LOW:   if (tick) begin
        state_nxt = HIGH;
        sample    = 1'b1;
      end
      HIGH:  if (tick) begin
        if (!last_bit) begin
          state_nxt = LOW;
          shift     = 1'b1;
        end else begin
          byte_end = 1'b1;
          if (byte_cnt == 9'd1) begin
            state_nxt = HOLD;
          end else if (!wr_cmd) begin
            state_nxt = LOW;
            load_data = 1'b1;
          end else if (wr_valid) begin
            state_nxt = LOW;
            load_data = 1'b1;
            wr_ready  = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      // sck is stretched low here until the next write byte shows up
      WAIT:  if (wr_valid) begin
        state_nxt = LOW;
        load_data = 1'b1;
        wr_ready  = 1'b1;
      end
      HOLD:  if (tick) state_nxt = GUARD;
      GUARD: if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      div   <= DIV_LOAD;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) div <= DIV_LOAD;
      else if (div != 8'd0)   div <= div - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wr_cmd   <= cmd_write;
      addr     <= cmd_addr;
      byte_cnt <= {1'b0, cmd_len} + 9'd1;
    end else if (byte_end) begin
      byte_cnt <= byte_cnt - 9'd1;
    end
    if (load_hdr) begin
      tx      <= hdr_byte;
      bit_cnt <= 3'd7;
      hdr     <= 1'b1;
    end else if (load_data) begin
      tx      <= wr_cmd ? wr_data : 8'h00;
      bit_cnt <= 3'd7;
      hdr     <= 1'b0;
    end else if (shift) begin
      tx      <= {tx[6:0], 1'b0};
      bit_cnt <= bit_cnt - 3'd1;
    end
    if (sample) rx <= {rx[6:0], miso};
  end

  // mosi changes only when LOW is entered, so it is stable across the rising sck edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mosi     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
    end else begin
      if (load_hdr)                                 mosi <= hdr_byte[7];
      else if (load_data)                           mosi <= wr_cmd ? wr_data[7] : 1'b0;
      else if (shift)                               mosi <= tx[6];
      else if (state_nxt == HOLD && state != HOLD)  mosi <= 1'b0;
      rd_valid <= sample && last_bit && !hdr && !wr_cmd;
      if (sample && last_bit && !hdr && !wr_cmd) rd_data <= {rx[6:0], miso};
    end
  end

endmodule

// File: tb/tb_spi_csr_master.sv
// Directed bench for spi_csr_master: a mosi/miso pin model plus per-scenario tasks
// with hand-computed expected bytes, pulse counts and cycle counts (CLK_DIV=2).
module tb_spi_csr_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [4:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy, sck, nss, mosi;
  logic       miso;

  int vectors = 0;
  int miscompares = 0;

  int   rise_total = 0;
  int   rise_base = 0;
  int   wr_total = 0;
  int   rd_total = 0;
  logic mosi_bits [0:1023];
  logic [7:0] rd_log [0:63];
  logic [7:0] resp [0:7];
  int   n_idx;

  spi_csr_master #(.A_WIDTH(5), .CLK_DIV(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .sck(sck), .nss(nss), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  always @(posedge sck) begin
    mosi_bits[rise_total % 1024] <= mosi;
    rise_total <= rise_total + 1;
  end

  always @(negedge clk) begin
    if (wr_ready === 1'b1) wr_total <= wr_total + 1;
    if (rd_valid === 1'b1) begin
      rd_log[rd_total % 64] <= rd_data;
      rd_total <= rd_total + 1;
    end
  end

  // Slave pin model: bit k of the stream is presented before the k-th rising sck
  always_comb begin
    miso  = 1'b0;
    n_idx = rise_total - rise_base;
    if (n_idx >= 0 && n_idx < 64) miso = resp[n_idx / 8][7 - (n_idx % 8)];
  end

  function automatic logic [7:0] get_byte(input int base, input int k);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[7-i] = mosi_bits[(base + 8*k + i) % 1024];
    return b;
  endfunction

  task automatic run_cmd(input logic w, input logic [4:0] a, input logic [7:0] l,
                         output int cyc, output int nss_low);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0; nss_low = 0;
    while (cyc < 5000) begin
      @(negedge clk);
      if (cmd_ready) break;
      cyc++;
      if (!nss) nss_low++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL reset_cmd_ready_in_reset got %b exp 0", cmd_ready); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({cmd_ready, wr_ready, rd_valid, busy, sck, nss, mosi} !== 7'b1000010) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy/wr/rv/busy/sck/nss/mosi=%b exp 1000010",
               {cmd_ready, wr_ready, rd_valid, busy, sck, nss, mosi});
    end
    vectors++;
    if (rd_data !== 8'h00) begin miscompares++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
  endtask

  task automatic test_write;
    int cyc, nl, wr0, rd0;
    rise_base = rise_total; wr0 = wr_total; rd0 = rd_total;
    wr_data = 8'hA5; wr_valid = 1'b1;
    run_cmd(1'b1, 5'd3, 8'd1, cyc, nl);
    wr_valid = 1'b0;
    vectors++;
    if (cyc !== 70) begin miscompares++; $display("FAIL write_cycles got %0d exp 70", cyc); end
    vectors++;
    if (nl !== 68) begin miscompares++; $display("FAIL write_nss_low got %0d exp 68", nl); end
    vectors++;
    if (rise_total - rise_base !== 16) begin miscompares++; $display("FAIL write_sck_rises got %0d exp 16", rise_total - rise_base); end
    vectors++;
    if (get_byte(rise_base, 0) !== 8'h83 || get_byte(rise_base, 1) !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_mosi got %h %h exp 83 a5", get_byte(rise_base, 0), get_byte(rise_base, 1));
    end
    vectors++;
    if (wr_total - wr0 !== 1) begin miscompares++; $display("FAIL write_wr_ready got %0d exp 1", wr_total - wr0); end
    vectors++;
    if (rd_total - rd0 !== 0) begin miscompares++; $display("FAIL write_rd_valid got %0d exp 0", rd_total - rd0); end
  endtask

  task automatic test_read;
    int cyc, nl, rd0;
    resp[0] = 8'hFF; resp[1] = 8'h3C; resp[2] = 8'hC3; resp[3] = 8'h00;
    rise_base = rise_total; rd0 = rd_total;
    run_cmd(1'b0, 5'h1F, 8'd2, cyc, nl);
    repeat (2) @(negedge clk);
    vectors++;
    if (get_byte(rise_base, 0) !== 8'h1F || get_byte(rise_base, 1) !== 8'h00 || get_byte(rise_base, 2) !== 8'h00) begin
      miscompares++;
      $display("FAIL read_mosi got %h %h %h exp 1f 00 00",
               get_byte(rise_base, 0), get_byte(rise_base, 1), get_byte(rise_base, 2));
    end
    vectors++;
    if (rd_total - rd0 !== 2) begin miscompares++; $display("FAIL read_rd_valid_count got %0d exp 2", rd_total - rd0); end
    vectors++;
    if (rd_log[rd0 % 64] !== 8'h3C || rd_log[(rd0 + 1) % 64] !== 8'hC3) begin
      miscompares++;
      $display("FAIL read_rd_data got %h %h exp 3c c3", rd_log[rd0 % 64], rd_log[(rd0 + 1) % 64]);
    end
    vectors++;
    if (cyc !== 102) begin miscompares++; $display("FAIL read_cycles got %0d exp 102", cyc); end
    vectors++;
    if (rd_data !== 8'hC3) begin miscompares++; $display("FAIL read_rd_data_hold got %h exp c3", rd_data); end
  endtask

  task automatic test_wait_state;
    int cyc, nl, wr0, t, viol, r20;
    rise_base = rise_total; wr0 = wr_total; t = 0; viol = 0; r20 = 0;
    wr_data = 8'h11; wr_valid = 1'b1;
    fork
      run_cmd(1'b1, 5'h0A, 8'd2, cyc, nl);
      begin
        while (wr_total == wr0 && t < 1000) begin @(negedge clk); t++; end
        wr_valid = 1'b0; wr_data = 8'h22;
        while (rise_total - rise_base < 16 && t < 1000) begin @(negedge clk); t++; end
        while (sck && t < 1000) begin @(negedge clk); t++; end
        repeat (20) begin
          @(negedge clk);
          if (sck !== 1'b0 || nss !== 1'b0) viol++;
        end
        r20 = rise_total - rise_base;
        @(posedge clk);
        #1 wr_valid = 1'b1;
        while (wr_total == wr0 + 1 && t < 1000) begin @(negedge clk); t++; end
        wr_valid = 1'b0;
      end
    join
    vectors++;
    if (t >= 1000) begin miscompares++; $display("FAIL wait_timeout got %0d exp <1000", t); end
    vectors++;
    if (viol !== 0 || r20 !== 16) begin miscompares++; $display("FAIL wait_stretch got viol=%0d rises=%0d exp 0 16", viol, r20); end
    vectors++;
    if (get_byte(rise_base, 0) !== 8'h8A || get_byte(rise_base, 1) !== 8'h11 || get_byte(rise_base, 2) !== 8'h22) begin
      miscompares++;
      $display("FAIL wait_mosi got %h %h %h exp 8a 11 22",
               get_byte(rise_base, 0), get_byte(rise_base, 1), get_byte(rise_base, 2));
    end
    vectors++;
    if (wr_total - wr0 !== 2) begin miscompares++; $display("FAIL wait_wr_ready got %0d exp 2", wr_total - wr0); end
    vectors++;
    if (cyc < 122) begin miscompares++; $display("FAIL wait_cycles got %0d exp >=122", cyc); end
  endtask

  task automatic test_header_only;
    int cyc, nl, rd0;
    rise_base = rise_total; rd0 = rd_total;
    run_cmd(1'b0, 5'h06, 8'd0, cyc, nl);
    repeat (2) @(negedge clk);
    vectors++;
    if (rise_total - rise_base !== 8) begin miscompares++; $display("FAIL hdr_only_rises got %0d exp 8", rise_total - rise_base); end
    vectors++;
    if (rd_total - rd0 !== 0) begin miscompares++; $display("FAIL hdr_only_rd_valid got %0d exp 0", rd_total - rd0); end
    vectors++;
    if (cyc !== 38) begin miscompares++; $display("FAIL hdr_only_cycles got %0d exp 38", cyc); end
    vectors++;
    if (get_byte(rise_base, 0) !== 8'h06) begin miscompares++; $display("FAIL hdr_only_mosi got %h exp 06", get_byte(rise_base, 0)); end
  endtask

  task automatic test_reset_mid;
    int cyc, nl, t, wr_s, rd_s;
    logic [2:0] pins;
    resp[1] = 8'h55; resp[2] = 8'hAA;
    rise_base = rise_total; t = 0; wr_s = 0; rd_s = 0; pins = '0;
    fork
      run_cmd(1'b0, 5'h04, 8'd2, cyc, nl);
      begin
        while (rise_total - rise_base < 11 && t < 1000) begin @(negedge clk); t++; end
        reset_n = 1'b0;
        wr_s = wr_total; rd_s = rd_total;
        @(posedge clk);
        #1 pins = {nss, sck, busy};
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
      end
    join
    vectors++;
    if (t >= 1000) begin miscompares++; $display("FAIL rstmid_timeout got %0d exp <1000", t); end
    vectors++;
    if (pins !== 3'b100) begin miscompares++; $display("FAIL rstmid_pins got nss/sck/busy=%b exp 100", pins); end
    repeat (40) @(negedge clk);
    vectors++;
    if (rd_total !== rd_s || wr_total !== wr_s) begin
      miscompares++;
      $display("FAIL rstmid_pulses got rd=%0d wr=%0d exp 0 0", rd_total - rd_s, wr_total - wr_s);
    end
    rise_base = rise_total;
    wr_data = 8'h3C; wr_valid = 1'b1;
    run_cmd(1'b1, 5'h07, 8'd1, cyc, nl);
    wr_valid = 1'b0;
    vectors++;
    if (cyc !== 70 || get_byte(rise_base, 0) !== 8'h87 || get_byte(rise_base, 1) !== 8'h3C) begin
      miscompares++;
      $display("FAIL rstmid_recover got cyc=%0d mosi=%h %h exp 70 87 3c",
               cyc, get_byte(rise_base, 0), get_byte(rise_base, 1));
    end
  endtask

  task automatic test_back_to_back;
    int cyc, accepts, falls, run, min_gap, rd0;
    logic prev_nss;
    rise_base = rise_total; rd0 = rd_total;
    cyc = 0; accepts = 0; falls = 0; run = 0; min_gap = 999; prev_nss = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'h05; cmd_len = 8'd0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cmd_ready && cmd_valid) accepts++;
      if (!nss && prev_nss) begin
        falls++;
        if (falls > 1 && run < min_gap) min_gap = run;
      end
      run = nss ? run + 1 : 0;
      prev_nss = nss;
      if (accepts == 3 && cmd_valid) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
      end else if (accepts == 3 && !cmd_valid && cmd_ready) begin
        break;
      end
    end
    vectors++;
    if (accepts !== 3 || falls !== 3) begin miscompares++; $display("FAIL b2b_transactions got acc=%0d falls=%0d exp 3 3", accepts, falls); end
    vectors++;
    if (min_gap !== 3) begin miscompares++; $display("FAIL b2b_nss_gap got %0d exp 3", min_gap); end
    vectors++;
    if (rise_total - rise_base !== 24) begin miscompares++; $display("FAIL b2b_rises got %0d exp 24", rise_total - rise_base); end
    vectors++;
    if (rd_total - rd0 !== 0) begin miscompares++; $display("FAIL b2b_rd_valid got %0d exp 0", rd_total - rd0); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) resp[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_wait_state();
    test_header_only();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got still running exp finished");
    $fatal(1);
  end

endmodule
